lpif_tx_scheduler: RTL and testbench
====================================

// Module: lpif_tx_scheduler
// PURPOSE
// - Shares the LPIF transmit bus (lp_data/lp_valid/lp_irdy) between a TLP requester and a DLLP requester.
// - Whole-packet arbitration: DLLP priority, with a TLP anti-starvation limit.
// - Converts beat-level sop/eop into per-byte lp_tlp_start/end and lp_dllp_start/end markers.
// - Gates new grants on link state; drains in-flight packets when the link drops.
// PARAMETERS
// - LPIF_BUS_WIDTH, 32, bus width in bits (multiple of 8); NB = LPIF_BUS_WIDTH/8 byte lanes.
// - MAX_DLLP_BURST, 4, consecutive DLLP grants allowed while a TLP is pending.
// - ACTIVE_STS, 4'h1, pl_state_sts encoding for Active.
// PORTS
// - lclk              in   1    LPIF clock
// - reset             in   1    synchronous, active-high reset
// - tlp_valid/dllp_valid      in   1    requester beat valid
// - tlp_ready/dllp_ready      out  1    requester beat accepted when valid&ready
// - tlp_data/dllp_data        in   W    beat data
// - tlp_bvalid/dllp_bvalid    in   NB   byte mask; contiguous from lane 0
// - tlp_sop/dllp_sop, tlp_eop/dllp_eop   in   1    first/last beat of packet
// - pl_linkup         in   1    link up
// - pl_state_sts      in   4    physical layer state
// - pl_trdy           in   1    PHY accepts current beat
// - lp_irdy           out  1    beat presented
// - lp_data           out  W    beat data
// - lp_valid          out  NB   byte valid
// - lp_tlp_start, lp_tlp_end, lp_dllp_start, lp_dllp_end   out  NB   per-byte markers
// - lp_tlpedb         out  NB   tied 0
// - pkt_drop          out  1    one-cycle pulse per packet drained
// BEHAVIOUR
// - Reset: all outputs 0; state IDLE; burst counter 0.
// - Output stage: single register.
//   - load_en = !lp_irdy || pl_trdy.
//   - Loads the accepted requester beat; lp_irdy=1 the cycle after acceptance.
//   - lp_irdy clears on pl_trdy with no new load.
//   - Holds stable while lp_irdy && !pl_trdy.
// - link_ok = pl_linkup && pl_state_sts==ACTIVE_STS.
// - FSM states: IDLE, TLP, DLLP, DRAIN.
//   - IDLE, link_ok:
//     - dllp_valid&dllp_sop, and (!tlp_valid || cnt<MAX_DLLP_BURST) -> DLLP.
//     - else tlp_valid&tlp_sop -> TLP.
//     - Decision and first-beat acceptance occur in the same cycle.
//   - TLP/DLLP:
//     - {x}_ready = load_en; no interleave mid-packet.
//     - eop accepted -> IDLE; the next grant can occur the following cycle.
//   - Any state, !pl_linkup with a packet open -> DRAIN.
//     - Immediately: lp_irdy=0 and the output register is cleared.
//   - DRAIN:
//     - Granted requester's ready=1 and beats are discarded.
//     - On eop: pkt_drop=1 -> IDLE.
// - Valid beats without sop while IDLE are consumed and discarded; no pkt_drop.
// - Burst counter cnt:
//   - +1 (saturating) on each DLLP grant while tlp_valid.
//   - Cleared on TLP grant or when tlp_valid=0 in IDLE.
// - Markers, registered with data:
//   - start bit 0 on sop beat.
//   - end bit at highest set bvalid lane on eop beat.
//   - Type (tlp/dllp) follows the granted requester.
//   - sop&eop in one beat sets both markers.
// - lp_valid = beat bvalid; zero whenever lp_irdy=0.
// - Reset mid-packet: abandons the packet, no pkt_drop, state IDLE next cycle.
// TESTING (W=32)
// - Single-beat DLLP 0xAABBCCDD, bvalid 4'hF, pl_trdy=1 -> next cycle:
//   - lp_irdy=1, lp_dllp_start=4'h1, lp_dllp_end=4'h8.
// - 3-beat TLP, last bvalid 4'h3, pl_trdy stalled 2 cycles on beat 2:
//   - lp_data held; lp_tlp_end=4'h2 on beat 3.
// - TLP and DLLP both valid in IDLE -> DLLP granted first, TLP next.
// - MAX_DLLP_BURST=4, continuous DLLPs with a TLP pending -> 4 DLLPs then the TLP.
// - pl_state_sts=4'h0 with requests -> no ready, lp_irdy=0; grant within 1 cycle of ACTIVE.
// - pl_linkup drops on TLP beat 2 of 4:
//   - lp_irdy=0 next cycle; beats 3-4 consumed; pkt_drop pulses once; IDLE.

Source files
------------

// File: rtl/lpif_tx_scheduler.sv
// LPIF transmit scheduler: arbitrates whole packets from a TLP requester and a
// DLLP requester onto one LPIF transmit bus. DLLPs win unless a pending TLP has
// already waited out MAX_DLLP_BURST DLLP grants. Beat sop/eop become per-byte
// start/end markers. In-flight packets are drained when the link drops.
module lpif_tx_scheduler #(
  parameter int         LPIF_BUS_WIDTH = 32,
  parameter int         MAX_DLLP_BURST = 4,
  parameter logic [3:0] ACTIVE_STS     = 4'h1
) (
  input  logic                        lclk,
  input  logic                        reset,
  input  logic                        tlp_valid,
  output logic                        tlp_ready,
  input  logic [LPIF_BUS_WIDTH-1:0]   tlp_data,
  input  logic [LPIF_BUS_WIDTH/8-1:0] tlp_bvalid,
  input  logic                        tlp_sop,
  input  logic                        tlp_eop,
  input  logic                        dllp_valid,
  output logic                        dllp_ready,
  input  logic [LPIF_BUS_WIDTH-1:0]   dllp_data,
  input  logic [LPIF_BUS_WIDTH/8-1:0] dllp_bvalid,
  input  logic                        dllp_sop,
  input  logic                        dllp_eop,
  input  logic                        pl_linkup,
  input  logic [3:0]                  pl_state_sts,
  input  logic                        pl_trdy,
  output logic                        lp_irdy,
  output logic [LPIF_BUS_WIDTH-1:0]   lp_data,
  output logic [LPIF_BUS_WIDTH/8-1:0] lp_valid,
  output logic [LPIF_BUS_WIDTH/8-1:0] lp_tlp_start,
  output logic [LPIF_BUS_WIDTH/8-1:0] lp_tlp_end,
  output logic [LPIF_BUS_WIDTH/8-1:0] lp_dllp_start,
  output logic [LPIF_BUS_WIDTH/8-1:0] lp_dllp_end,
  output logic [LPIF_BUS_WIDTH/8-1:0] lp_tlpedb,
  output logic                        pkt_drop
);

  localparam int NB    = LPIF_BUS_WIDTH / 8;
  localparam int CNT_W = $clog2(MAX_DLLP_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DLLP_BURST);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TLP   = 2'd1,
    ST_DLLP  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic             gnt_dllp, gnt_dllp_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  logic             load_en;
  logic             link_ok;
  logic             ld;
  logic             ld_dllp;
  logic             flush;
  logic             drop;

  logic [LPIF_BUS_WIDTH-1:0] beat_data;
  logic [NB-1:0]             beat_bv;
  logic                      beat_sop;
  logic                      beat_eop;

  // Start marker always sits on lane 0 of the first beat.
  function automatic logic [NB-1:0] start_mark(input logic sop);
    logic [NB-1:0] m;
    m    = '0;
    m[0] = sop;
    return m;
  endfunction

  // End marker is the highest valid lane of the last beat (mask is contiguous).
  function automatic logic [NB-1:0] end_mark(input logic [NB-1:0] bv, input logic eop);
    logic [NB-1:0] m;
    m = '0;
    if (eop) begin
      for (int i = 0; i < NB; i++) begin
        if (bv[i]) begin
          m    = '0;
          m[i] = 1'b1;
        end
      end
    end
    return m;
  endfunction

  assign load_en   = !lp_irdy || pl_trdy;
  assign link_ok   = pl_linkup && (pl_state_sts == ACTIVE_STS);
  assign lp_tlpedb = '0;

  assign beat_data = ld_dllp ? dllp_data   : tlp_data;
  assign beat_bv   = ld_dllp ? dllp_bvalid : tlp_bvalid;
  assign beat_sop  = ld_dllp ? dllp_sop    : tlp_sop;
  assign beat_eop  = ld_dllp ? dllp_eop    : tlp_eop;

  // Arbitration / packet tracking: next state, requester readies, load and drain controls.
  always_comb begin
    state_nxt    = state;
    gnt_dllp_nxt = gnt_dllp;
    cnt_nxt      = cnt;
    tlp_ready    = 1'b0;
    dllp_ready   = 1'b0;
    ld           = 1'b0;
    ld_dllp      = 1'b0;
    flush        = 1'b0;
    drop         = 1'b0;
    case (state)
      ST_IDLE: begin
        // Orphan beats (no sop) are swallowed while nothing is open.
        tlp_ready  = tlp_valid && !tlp_sop;
        dllp_ready = dllp_valid && !dllp_sop;
        if (!tlp_valid) cnt_nxt = '0;
        if (link_ok && load_en) begin
          if (dllp_valid && dllp_sop && (!tlp_valid || cnt < CNT_MAX)) begin
            dllp_ready   = 1'b1;
            ld           = 1'b1;
            ld_dllp      = 1'b1;
            gnt_dllp_nxt = 1'b1;
            if (tlp_valid && cnt != CNT_MAX) cnt_nxt = cnt + 1'b1;
            if (!dllp_eop) state_nxt = ST_DLLP;
          end else if (tlp_valid && tlp_sop) begin
            tlp_ready    = 1'b1;
            ld           = 1'b1;
            gnt_dllp_nxt = 1'b0;
            cnt_nxt      = '0;
            if (!tlp_eop) state_nxt = ST_TLP;
          end
        end
      end
      ST_TLP: begin
        if (!pl_linkup) begin
          tlp_ready = 1'b1;
          flush     = 1'b1;
          if (tlp_valid && tlp_eop) begin
            drop      = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            state_nxt = ST_DRAIN;
          end
        end else begin
          tlp_ready = load_en;
          ld        = tlp_valid && load_en;
          if (tlp_valid && load_en && tlp_eop) state_nxt = ST_IDLE;
        end
      end
      ST_DLLP: begin
        ld_dllp = 1'b1;
        if (!pl_linkup) begin
          dllp_ready = 1'b1;
          flush      = 1'b1;
          if (dllp_valid && dllp_eop) begin
            drop      = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            state_nxt = ST_DRAIN;
          end
        end else begin
          dllp_ready = load_en;
          ld         = dllp_valid && load_en;
          if (dllp_valid && load_en && dllp_eop) state_nxt = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        flush = 1'b1;
        if (gnt_dllp) begin
          dllp_ready = 1'b1;
          if (dllp_valid && dllp_eop) begin
            drop      = 1'b1;
            state_nxt = ST_IDLE;
          end
        end else begin
          tlp_ready = 1'b1;
          if (tlp_valid && tlp_eop) begin
            drop      = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Control state: FSM, granted requester, DLLP burst counter, drop pulse.
  always_ff @(posedge lclk) begin
    if (reset) begin
      state    <= ST_IDLE;
      gnt_dllp <= 1'b0;
      cnt      <= '0;
      pkt_drop <= 1'b0;
    end else begin
      state    <= state_nxt;
      gnt_dllp <= gnt_dllp_nxt;
      cnt      <= cnt_nxt;
      pkt_drop <= drop;
    end
  end

  // Output register: loads accepted beats with their markers, holds under backpressure.
  always_ff @(posedge lclk) begin
    if (reset || flush) begin
      lp_irdy       <= 1'b0;
      lp_data       <= '0;
      lp_valid      <= '0;
      lp_tlp_start  <= '0;
      lp_tlp_end    <= '0;
      lp_dllp_start <= '0;
      lp_dllp_end   <= '0;
    end else if (load_en) begin
      if (ld) begin
        lp_irdy  <= 1'b1;
        lp_data  <= beat_data;
        lp_valid <= beat_bv;
        if (ld_dllp) begin
          lp_tlp_start  <= '0;
          lp_tlp_end    <= '0;
          lp_dllp_start <= start_mark(beat_sop);
          lp_dllp_end   <= end_mark(beat_bv, beat_eop);
        end else begin
          lp_tlp_start  <= start_mark(beat_sop);
          lp_tlp_end    <= end_mark(beat_bv, beat_eop);
          lp_dllp_start <= '0;
          lp_dllp_end   <= '0;
        end
      end else begin
        lp_irdy       <= 1'b0;
        lp_valid      <= '0;
        lp_tlp_start  <= '0;
        lp_tlp_end    <= '0;
        lp_dllp_start <= '0;
        lp_dllp_end   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_lpif_tx_scheduler.sv
// Bench for lpif_tx_scheduler: directed scenarios plus random two-requester
// traffic checked against a packet-level reference (per-source beat queues).
module tb_lpif_tx_scheduler;

  localparam int W    = 32;
  localparam int NB   = W / 8;
  localparam int MAXB = 4;

  logic          lclk = 1'b0;
  logic          reset;
  logic          tlp_valid, tlp_ready, tlp_sop, tlp_eop;
  logic [W-1:0]  tlp_data;
  logic [NB-1:0] tlp_bvalid;
  logic          dllp_valid, dllp_ready, dllp_sop, dllp_eop;
  logic [W-1:0]  dllp_data;
  logic [NB-1:0] dllp_bvalid;
  logic          pl_linkup, pl_trdy;
  logic [3:0]    pl_state_sts;
  logic          lp_irdy, pkt_drop;
  logic [W-1:0]  lp_data;
  logic [NB-1:0] lp_valid, lp_tlp_start, lp_tlp_end, lp_dllp_start, lp_dllp_end, lp_tlpedb;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic [W-1:0]  data;
    logic [NB-1:0] bv;
    logic          sop;
    logic          eop;
  } beat_t;

  beat_t q_tlp[$];
  beat_t q_dllp[$];
  bit    drivers_done;
  bit    mon_stop;

  lpif_tx_scheduler #(.LPIF_BUS_WIDTH(W), .MAX_DLLP_BURST(MAXB), .ACTIVE_STS(4'h1)) dut (
    .lclk(lclk), .reset(reset),
    .tlp_valid(tlp_valid), .tlp_ready(tlp_ready), .tlp_data(tlp_data),
    .tlp_bvalid(tlp_bvalid), .tlp_sop(tlp_sop), .tlp_eop(tlp_eop),
    .dllp_valid(dllp_valid), .dllp_ready(dllp_ready), .dllp_data(dllp_data),
    .dllp_bvalid(dllp_bvalid), .dllp_sop(dllp_sop), .dllp_eop(dllp_eop),
    .pl_linkup(pl_linkup), .pl_state_sts(pl_state_sts), .pl_trdy(pl_trdy),
    .lp_irdy(lp_irdy), .lp_data(lp_data), .lp_valid(lp_valid),
    .lp_tlp_start(lp_tlp_start), .lp_tlp_end(lp_tlp_end),
    .lp_dllp_start(lp_dllp_start), .lp_dllp_end(lp_dllp_end),
    .lp_tlpedb(lp_tlpedb), .pkt_drop(pkt_drop)
  );

  always #5 lclk = ~lclk;

  initial begin
    #500000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge lclk);
    #1;
  endtask

  task automatic set_tlp(input logic v, input logic [W-1:0] d, input logic [NB-1:0] bv,
                         input logic s, input logic e);
    tlp_valid = v; tlp_data = d; tlp_bvalid = bv; tlp_sop = s; tlp_eop = e;
  endtask

  task automatic set_dllp(input logic v, input logic [W-1:0] d, input logic [NB-1:0] bv,
                          input logic s, input logic e);
    dllp_valid = v; dllp_data = d; dllp_bvalid = bv; dllp_sop = s; dllp_eop = e;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_tlp(1'b0, '0, '0, 1'b0, 1'b0);
    set_dllp(1'b0, '0, '0, 1'b0, 1'b0);
    pl_linkup = 1'b1; pl_state_sts = 4'h1; pl_trdy = 1'b1;
    repeat (3) step();
    @(negedge lclk);
    n_assert++;
    if ({lp_irdy, lp_data, lp_valid, lp_tlp_start, lp_tlp_end, lp_dllp_start, lp_dllp_end,
         lp_tlpedb, pkt_drop, tlp_ready, dllp_ready} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs irdy=%b data=%h valid=%h drop=%b expected all zero",
               lp_irdy, lp_data, lp_valid, pkt_drop);
    end
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_single_dllp();
    set_dllp(1'b1, 32'hAABBCCDD, 4'hF, 1'b1, 1'b1);
    pl_trdy = 1'b1;
    @(negedge lclk);
    n_assert++;
    if (dllp_ready !== 1'b1) begin
      n_fail++; $display("FAIL single_dllp_ready got %b expected 1", dllp_ready);
    end
    step();
    set_dllp(1'b0, '0, '0, 1'b0, 1'b0);
    @(negedge lclk);
    n_assert++;
    if ({lp_irdy, lp_data, lp_valid, lp_dllp_start, lp_dllp_end, lp_tlp_start, lp_tlp_end}
        !== {1'b1, 32'hAABBCCDD, 4'hF, 4'h1, 4'h8, 4'h0, 4'h0}) begin
      n_fail++;
      $display("FAIL single_dllp_out irdy=%b data=%h valid=%h ds=%h de=%h ts=%h te=%h expected 1 aabbccdd f 1 8 0 0",
               lp_irdy, lp_data, lp_valid, lp_dllp_start, lp_dllp_end, lp_tlp_start, lp_tlp_end);
    end
    step();
    @(negedge lclk);
    n_assert++;
    if ({lp_irdy, lp_valid} !== 5'b0) begin
      n_fail++; $display("FAIL single_dllp_idle irdy=%b valid=%h expected 0 0", lp_irdy, lp_valid);
    end
    step();
  endtask

  task automatic test_tlp_stall();
    set_tlp(1'b1, 32'h11111111, 4'hF, 1'b1, 1'b0);
    pl_trdy = 1'b1;
    @(negedge lclk);
    n_assert++;
    if (tlp_ready !== 1'b1) begin n_fail++; $display("FAIL stall_b1_ready got %b expected 1", tlp_ready); end
    step();
    set_tlp(1'b1, 32'h22222222, 4'hF, 1'b0, 1'b0);
    @(negedge lclk);
    n_assert++;
    if ({lp_irdy, lp_data, lp_tlp_start, tlp_ready} !== {1'b1, 32'h11111111, 4'h1, 1'b1}) begin
      n_fail++; $display("FAIL stall_b1_out irdy=%b data=%h ts=%h rdy=%b expected 1 11111111 1 1",
                         lp_irdy, lp_data, lp_tlp_start, tlp_ready);
    end
    step();
    set_tlp(1'b1, 32'h33333333, 4'h3, 1'b0, 1'b1);
    pl_trdy = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge lclk);
      n_assert++;
      if ({lp_irdy, lp_data, lp_tlp_start, lp_tlp_end, tlp_ready} !== {1'b1, 32'h22222222, 4'h0, 4'h0, 1'b0}) begin
        n_fail++; $display("FAIL stall_hold_%0d irdy=%b data=%h rdy=%b expected 1 22222222 0", c,
                           lp_irdy, lp_data, tlp_ready);
      end
      if (c == 0) step();
    end
    step();
    pl_trdy = 1'b1;
    @(negedge lclk);
    n_assert++;
    if ({lp_data, tlp_ready} !== {32'h22222222, 1'b1}) begin
      n_fail++; $display("FAIL stall_release data=%h rdy=%b expected 22222222 1", lp_data, tlp_ready);
    end
    step();
    set_tlp(1'b0, '0, '0, 1'b0, 1'b0);
    @(negedge lclk);
    n_assert++;
    if ({lp_irdy, lp_data, lp_valid, lp_tlp_start, lp_tlp_end} !== {1'b1, 32'h33333333, 4'h3, 4'h0, 4'h2}) begin
      n_fail++; $display("FAIL stall_b3_out irdy=%b data=%h valid=%h ts=%h te=%h expected 1 33333333 3 0 2",
                         lp_irdy, lp_data, lp_valid, lp_tlp_start, lp_tlp_end);
    end
    step();
    step();
  endtask

  task automatic test_priority();
    set_tlp(1'b1, 32'hCAFE0001, 4'hF, 1'b1, 1'b1);
    set_dllp(1'b1, 32'hD0D00001, 4'hF, 1'b1, 1'b1);
    @(negedge lclk);
    n_assert++;
    if ({dllp_ready, tlp_ready} !== 2'b10) begin
      n_fail++; $display("FAIL prio_first dllp_rdy=%b tlp_rdy=%b expected 1 0", dllp_ready, tlp_ready);
    end
    step();
    set_dllp(1'b0, '0, '0, 1'b0, 1'b0);
    @(negedge lclk);
    n_assert++;
    if ({lp_dllp_start, lp_data, tlp_ready} !== {4'h1, 32'hD0D00001, 1'b1}) begin
      n_fail++; $display("FAIL prio_second ds=%h data=%h tlp_rdy=%b expected 1 d0d00001 1",
                         lp_dllp_start, lp_data, tlp_ready);
    end
    step();
    set_tlp(1'b0, '0, '0, 1'b0, 1'b0);
    @(negedge lclk);
    n_assert++;
    if ({lp_tlp_start, lp_tlp_end, lp_data} !== {4'h1, 4'h8, 32'hCAFE0001}) begin
      n_fail++; $display("FAIL prio_tlp_out ts=%h te=%h data=%h expected 1 8 cafe0001",
                         lp_tlp_start, lp_tlp_end, lp_data);
    end
    step();
    step();
  endtask

  task automatic test_burst_limit();
    int  n_d;
    bit  tlp_seen;
    n_d = 0; tlp_seen = 1'b0;
    pl_trdy = 1'b1;
    set_tlp(1'b1, 32'h7777AAAA, 4'hF, 1'b1, 1'b1);
    set_dllp(1'b1, $urandom, 4'hF, 1'b1, 1'b1);
    for (int c = 0; c < 12 && !tlp_seen; c++) begin
      @(negedge lclk);
      if (tlp_ready) begin
        tlp_seen = 1'b1;
        n_assert++;
        if (dllp_ready !== 1'b0) begin
          n_fail++; $display("FAIL burst_exclusive dllp_rdy=%b expected 0 on tlp grant", dllp_ready);
        end
      end else if (dllp_ready) begin
        n_d++;
      end
      step();
      if (tlp_seen) tlp_valid = 1'b0;
      dllp_data = $urandom;
    end
    n_assert++;
    if (!tlp_seen || n_d != MAXB) begin
      n_fail++; $display("FAIL burst_count dllp_grants=%0d tlp_granted=%b expected %0d 1", n_d, tlp_seen, MAXB);
    end
    @(negedge lclk);
    n_assert++;
    if (lp_tlp_start !== 4'h1 || lp_data !== 32'h7777AAAA) begin
      n_fail++; $display("FAIL burst_tlp_out ts=%h data=%h expected 1 7777aaaa", lp_tlp_start, lp_data);
    end
    step();
    set_dllp(1'b0, '0, '0, 1'b0, 1'b0);
    step();
    step();
  endtask

  task automatic test_link_state();
    pl_state_sts = 4'h0;
    set_tlp(1'b1, 32'h5A5A5A5A, 4'hF, 1'b1, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(negedge lclk);
      n_assert++;
      if ({tlp_ready, lp_irdy} !== 2'b00) begin
        n_fail++; $display("FAIL link_gate_%0d tlp_rdy=%b irdy=%b expected 0 0", c, tlp_ready, lp_irdy);
      end
      step();
    end
    pl_state_sts = 4'h1;
    @(negedge lclk);
    n_assert++;
    if (tlp_ready !== 1'b1) begin n_fail++; $display("FAIL link_active_grant tlp_rdy=%b expected 1", tlp_ready); end
    step();
    set_tlp(1'b0, '0, '0, 1'b0, 1'b0);
    @(negedge lclk);
    n_assert++;
    if ({lp_irdy, lp_data} !== {1'b1, 32'h5A5A5A5A}) begin
      n_fail++; $display("FAIL link_active_out irdy=%b data=%h expected 1 5a5a5a5a", lp_irdy, lp_data);
    end
    step();
    step();
  endtask

  task automatic test_link_drop();
    int drops;
    drops = 0;
    pl_trdy = 1'b1;
    set_tlp(1'b1, 32'h0000B001, 4'hF, 1'b1, 1'b0);
    step();
    set_tlp(1'b1, 32'h0000B002, 4'hF, 1'b0, 1'b0);
    pl_linkup = 1'b0;
    @(negedge lclk);
    n_assert++;
    if (tlp_ready !== 1'b1) begin n_fail++; $display("FAIL drop_b2_consumed tlp_rdy=%b expected 1", tlp_ready); end
    step();
    set_tlp(1'b1, 32'h0000B003, 4'hF, 1'b0, 1'b0);
    @(negedge lclk);
    n_assert++;
    if ({lp_irdy, lp_data, lp_valid, tlp_ready} !== {1'b0, 32'h0, 4'h0, 1'b1}) begin
      n_fail++; $display("FAIL drop_cleared irdy=%b data=%h valid=%h rdy=%b expected 0 0 0 1",
                         lp_irdy, lp_data, lp_valid, tlp_ready);
    end
    drops += int'(pkt_drop);
    step();
    set_tlp(1'b1, 32'h0000B004, 4'h1, 1'b0, 1'b1);
    @(negedge lclk);
    n_assert++;
    if ({lp_irdy, tlp_ready} !== 2'b01) begin
      n_fail++; $display("FAIL drop_b4 irdy=%b rdy=%b expected 0 1", lp_irdy, tlp_ready);
    end
    drops += int'(pkt_drop);
    step();
    set_tlp(1'b0, '0, '0, 1'b0, 1'b0);
    pl_linkup = 1'b1;
    @(negedge lclk);
    n_assert++;
    if ({pkt_drop, lp_irdy} !== 2'b10) begin
      n_fail++; $display("FAIL drop_pulse pkt_drop=%b irdy=%b expected 1 0", pkt_drop, lp_irdy);
    end
    drops += int'(pkt_drop);
    step();
    set_tlp(1'b1, 32'h0000C001, 4'hF, 1'b1, 1'b1);
    @(negedge lclk);
    drops += int'(pkt_drop);
    n_assert++;
    if (tlp_ready !== 1'b1) begin n_fail++; $display("FAIL drop_back_idle tlp_rdy=%b expected 1", tlp_ready); end
    n_assert++;
    if (drops != 1) begin n_fail++; $display("FAIL drop_count pulses=%0d expected 1", drops); end
    step();
    set_tlp(1'b0, '0, '0, 1'b0, 1'b0);
    step();
    step();
  endtask

  task automatic test_reset_mid_packet();
    set_tlp(1'b1, 32'h0000E001, 4'hF, 1'b1, 1'b0);
    step();
    set_tlp(1'b1, 32'h0000E002, 4'hF, 1'b0, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    set_tlp(1'b1, 32'h0000F001, 4'hF, 1'b1, 1'b1);
    @(negedge lclk);
    n_assert++;
    if ({lp_irdy, pkt_drop, tlp_ready} !== 3'b001) begin
      n_fail++; $display("FAIL rstmid_state irdy=%b drop=%b rdy=%b expected 0 0 1", lp_irdy, pkt_drop, tlp_ready);
    end
    step();
    set_tlp(1'b0, '0, '0, 1'b0, 1'b0);
    @(negedge lclk);
    n_assert++;
    if ({lp_irdy, lp_tlp_start, lp_data} !== {1'b1, 4'h1, 32'h0000F001}) begin
      n_fail++; $display("FAIL rstmid_new irdy=%b ts=%h data=%h expected 1 1 0000f001", lp_irdy, lp_tlp_start, lp_data);
    end
    step();
    step();
  endtask

  task automatic drive_src(input bit is_dllp, input int npkt);
    step();
    for (int p = 0; p < npkt; p++) begin
      int    len;
      beat_t pkt[$];
      repeat ($urandom_range(0, 3)) step();
      len = $urandom_range(1, 4);
      for (int b = 0; b < len; b++) begin
        beat_t bt;
        bt.data = $urandom;
        bt.sop  = (b == 0);
        bt.eop  = (b == len - 1);
        bt.bv   = bt.eop ? NB'((1 << $urandom_range(1, NB)) - 1) : {NB{1'b1}};
        pkt.push_back(bt);
        if (is_dllp) q_dllp.push_back(bt); else q_tlp.push_back(bt);
      end
      foreach (pkt[b]) begin
        int w;
        if (is_dllp) set_dllp(1'b1, pkt[b].data, pkt[b].bv, pkt[b].sop, pkt[b].eop);
        else         set_tlp(1'b1, pkt[b].data, pkt[b].bv, pkt[b].sop, pkt[b].eop);
        w = 0;
        forever begin
          @(negedge lclk);
          if (is_dllp ? dllp_ready : tlp_ready) break;
          w++;
          if (w > 500) begin
            n_assert++; n_fail++;
            $display("FAIL rand_ready_timeout src_dllp=%b waited=%0d expected <=500", is_dllp, w);
            break;
          end
        end
        step();
      end
      if (is_dllp) set_dllp(1'b0, '0, '0, 1'b0, 1'b0);
      else         set_tlp(1'b0, '0, '0, 1'b0, 1'b0);
    end
  endtask

  task automatic monitor();
    bit    open;
    bit    cur_dllp;
    int    cycles;
    beat_t e;
    logic [NB-1:0] es, ee;
    open = 1'b0; cur_dllp = 1'b0; cycles = 0;
    while (!(drivers_done && !open && q_tlp.size() == 0 && q_dllp.size() == 0) && cycles < 20000) begin
      @(negedge lclk);
      cycles++;
      if (lp_irdy && pl_trdy) begin
        if (!open) begin
          if (lp_tlp_start[0])       cur_dllp = 1'b0;
          else if (lp_dllp_start[0]) cur_dllp = 1'b1;
          else begin
            n_assert++; n_fail++;
            $display("FAIL rand_no_start ts=%h ds=%h expected a start marker", lp_tlp_start, lp_dllp_start);
            continue;
          end
        end
        if ((cur_dllp ? q_dllp.size() : q_tlp.size()) == 0) begin
          n_assert++; n_fail++;
          $display("FAIL rand_unexpected_beat data=%h dllp=%b expected no beat", lp_data, cur_dllp);
          open = 1'b0;
          continue;
        end
        e = cur_dllp ? q_dllp.pop_front() : q_tlp.pop_front();
        open = !e.eop;
        es = e.sop ? NB'(1) : '0;
        ee = e.eop ? NB'(1 << ($countones(e.bv) - 1)) : '0;
        n_assert++;
        if ({lp_data, lp_valid} !== {e.data, e.bv}) begin
          n_fail++; $display("FAIL rand_beat data=%h valid=%h expected %h %h", lp_data, lp_valid, e.data, e.bv);
        end
        n_assert++;
        if ({lp_tlp_start, lp_tlp_end, lp_dllp_start, lp_dllp_end} !==
            (cur_dllp ? {{2*NB{1'b0}}, es, ee} : {es, ee, {2*NB{1'b0}}})) begin
          n_fail++; $display("FAIL rand_markers ts=%h te=%h ds=%h de=%h dllp=%b expected start %h end %h",
                             lp_tlp_start, lp_tlp_end, lp_dllp_start, lp_dllp_end, cur_dllp, es, ee);
        end
      end
    end
    n_assert++;
    if (cycles >= 20000) begin
      n_fail++; $display("FAIL rand_complete left_tlp=%0d left_dllp=%0d expected 0 0", q_tlp.size(), q_dllp.size());
    end
  endtask

  task automatic test_random_traffic();
    drivers_done = 1'b0;
    mon_stop     = 1'b0;
    fork
      begin
        fork
          drive_src(1'b0, 25);
          drive_src(1'b1, 25);
        join
        drivers_done = 1'b1;
      end
      begin
        while (!mon_stop) begin
          step();
          pl_trdy = ($urandom_range(0, 3) != 0);
        end
      end
      begin
        monitor();
        mon_stop = 1'b1;
      end
    join
    pl_trdy = 1'b1;
    step();
    step();
  endtask

  initial begin
    test_reset();
    test_single_dllp();
    test_tlp_stall();
    test_priority();
    test_burst_limit();
    test_link_state();
    test_link_drop();
    test_reset_mid_packet();
    test_random_traffic();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
